rabbit_frame_receiver: RTL and testbench

Front-end stage of the Rabbit-to-FPGA link. It captures bytes strobed in by the Rabbit microcontroller on an 8-bit parallel bus and assembles them into a 184-bit (23-byte) frame. Each complete frame is published as `whole184` with a one-cycle `FRAME_VALID` pulse. Its output feeds the byte-window converter and hex display stage directly.

---
 rtl/rabbit_frame_receiver.sv | 231 +++++++++++++++++++++++
 tb/tb_rabbit_frame_receiver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rabbit_frame_receiver.sv
// rtl/rabbit_frame_receiver.sv - Rabbit parallel-bus byte capture and 184-bit frame assembly
// Optional feature macro: RABBIT_CHECKSUM_EN (adds a trailing sum byte, 24-byte frames, CKSUM_ERR)
module rabbit_frame_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic         FITTYMEGA,
  input  logic         RESET_N,
  input  logic [7:0]   RABBIT_DATA,
  input  logic         RABBIT_STROBE,
  input  logic         RABBIT_SYNC,
  output logic [0:183] whole184,
  output logic         FRAME_VALID,
  output logic [7:0]   FRAME_COUNT,
  output logic         BUSY,
  output logic         TIMEOUT_ERR,
  output logic         OVERRUN_ERR,
  output logic         CKSUM_ERR,
  input  logic         CLEAR_ERR
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECV    = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

`ifdef RABBIT_CHECKSUM_EN
  localparam logic [4:0] LAST_IDX = 5'd23;
`else
  localparam logic [4:0] LAST_IDX = 5'd22;
`endif
  localparam logic [4:0]  DATA_LAST = 5'd22;
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  // Synchronisers: two stages each, third stage on strobe/sync for edge detect
  logic         stb_s1_q, stb_s2_q, stb_s3_q;
  logic         stb_s1_d, stb_s2_d, stb_s3_d;
  logic         syn_s1_q, syn_s2_q, syn_s3_q;
  logic         syn_s1_d, syn_s2_d, syn_s3_d;
  logic [7:0]   dat_s1_q, dat_s2_q;
  logic [7:0]   dat_s1_d, dat_s2_d;

  state_t       state_q, state_d;
  logic [4:0]   byte_cnt_q, byte_cnt_d;
  logic [15:0]  tmo_cnt_q, tmo_cnt_d;
  logic [0:183] shadow_q, shadow_d;
  logic [0:183] whole_q, whole_d;
  logic [7:0]   count_q, count_d;
  logic         terr_q, terr_d;
  logic         oerr_q, oerr_d;
`ifdef RABBIT_CHECKSUM_EN
  logic         cerr_q, cerr_d;
  logic [7:0]   sum_q, sum_d;
`endif

  logic         stb_edge, syn_edge;
  logic         wr_en;
  logic [4:0]   wr_idx;
  logic         terr_set, oerr_set, cerr_set;
  logic [15:0]  tmo_inc;

  assign stb_edge = stb_s2_q & ~stb_s3_q;
  assign syn_edge = syn_s2_q & ~syn_s3_q;
  assign tmo_inc  = tmo_cnt_q + 16'd1;

  // State register: every flop in the block, async active-low reset
  always_ff @(posedge FITTYMEGA or negedge RESET_N) begin
    if (!RESET_N) begin
      stb_s1_q   <= 1'b0;
      stb_s2_q   <= 1'b0;
      stb_s3_q   <= 1'b0;
      syn_s1_q   <= 1'b0;
      syn_s2_q   <= 1'b0;
      syn_s3_q   <= 1'b0;
      dat_s1_q   <= 8'd0;
      dat_s2_q   <= 8'd0;
      state_q    <= S_IDLE;
      byte_cnt_q <= 5'd0;
      tmo_cnt_q  <= 16'd0;
      shadow_q   <= '0;
      whole_q    <= '0;
      count_q    <= 8'd0;
      terr_q     <= 1'b0;
      oerr_q     <= 1'b0;
`ifdef RABBIT_CHECKSUM_EN
      cerr_q     <= 1'b0;
      sum_q      <= 8'd0;
`endif
    end else begin
      stb_s1_q   <= stb_s1_d;
      stb_s2_q   <= stb_s2_d;
      stb_s3_q   <= stb_s3_d;
      syn_s1_q   <= syn_s1_d;
      syn_s2_q   <= syn_s2_d;
      syn_s3_q   <= syn_s3_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      shadow_q   <= shadow_d;
      whole_q    <= whole_d;
      count_q    <= count_d;
      terr_q     <= terr_d;
      oerr_q     <= oerr_d;
`ifdef RABBIT_CHECKSUM_EN
      cerr_q     <= cerr_d;
      sum_q      <= sum_d;
`endif
    end
  end

  // Next-state logic: byte capture, timeout, SYNC restart and publish
  always_comb begin
    stb_s1_d   = RABBIT_STROBE;
    stb_s2_d   = stb_s1_q;
    stb_s3_d   = stb_s2_q;
    syn_s1_d   = RABBIT_SYNC;
    syn_s2_d   = syn_s1_q;
    syn_s3_d   = syn_s2_q;
    dat_s1_d   = RABBIT_DATA;
    dat_s2_d   = dat_s1_q;
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    shadow_d   = shadow_q;
    count_d    = count_q;
    wr_en      = 1'b0;
    wr_idx     = byte_cnt_q;
    terr_set   = 1'b0;
    oerr_set   = 1'b0;
    cerr_set   = 1'b0;
`ifdef RABBIT_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        tmo_cnt_d = 16'd0;
      end
      S_RECV: begin
        if (stb_edge) begin
          wr_en      = 1'b1;
          byte_cnt_d = byte_cnt_q + 5'd1;
          tmo_cnt_d  = 16'd0;
          if (byte_cnt_q == LAST_IDX) begin
`ifdef RABBIT_CHECKSUM_EN
            // Final byte is the sum of the data bytes; a mismatch drops the frame
            if (dat_s2_q == sum_q) begin
              state_d = S_PUBLISH;
            end else begin
              state_d  = S_IDLE;
              cerr_set = 1'b1;
              shadow_d = '0;
            end
`else
            state_d = S_PUBLISH;
`endif
            byte_cnt_d = 5'd0;
          end
        end else if (tmo_inc == TMO_LIMIT) begin
          terr_set   = 1'b1;
          state_d    = S_IDLE;
          byte_cnt_d = 5'd0;
          tmo_cnt_d  = 16'd0;
          shadow_d   = '0;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end
      S_PUBLISH: begin
        state_d = S_IDLE;
        count_d = count_q + 8'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // SYNC wins over everything else; a coincident strobe becomes byte 0
    if (syn_edge) begin
      oerr_set   = (state_q == S_RECV) && (byte_cnt_q != 5'd0);
      state_d    = S_RECV;
      byte_cnt_d = 5'd0;
      tmo_cnt_d  = 16'd0;
      shadow_d   = '0;
      wr_en      = 1'b0;
      cerr_set   = 1'b0;
`ifdef RABBIT_CHECKSUM_EN
      sum_d      = 8'd0;
`endif
      if (stb_edge) begin
        wr_en      = 1'b1;
        wr_idx     = 5'd0;
        byte_cnt_d = 5'd1;
      end
    end

    if (wr_en && (wr_idx <= DATA_LAST)) begin
      shadow_d[{wr_idx, 3'b000} +: 8] = dat_s2_q;
`ifdef RABBIT_CHECKSUM_EN
      sum_d = (syn_edge ? 8'd0 : sum_q) + dat_s2_q;
`endif
    end

    // whole184 is loaded on entry to PUBLISH so it is visible with FRAME_VALID
    whole_d = (state_d == S_PUBLISH && state_q != S_PUBLISH) ? shadow_d : whole_q;

    terr_d = CLEAR_ERR ? 1'b0 : (terr_q | terr_set);
    oerr_d = CLEAR_ERR ? 1'b0 : (oerr_q | oerr_set);
`ifdef RABBIT_CHECKSUM_EN
    cerr_d = CLEAR_ERR ? 1'b0 : (cerr_q | cerr_set);
`endif
  end

  // Outputs: decoded from registered state only
  always_comb begin
    whole184    = whole_q;
    FRAME_VALID = (state_q == S_PUBLISH);
    FRAME_COUNT = count_q;
    BUSY        = (state_q == S_RECV) && (byte_cnt_q != 5'd0);
    TIMEOUT_ERR = terr_q;
    OVERRUN_ERR = oerr_q;
`ifdef RABBIT_CHECKSUM_EN
    CKSUM_ERR   = cerr_q;
`else
    CKSUM_ERR   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rabbit_frame_receiver.sv
// tb/tb_rabbit_frame_receiver.sv - directed self-checking bench for rabbit_frame_receiver
module tb_rabbit_frame_receiver;

  localparam int T = 40;
`ifdef RABBIT_CHECKSUM_EN
  localparam int NB = 24;
`else
  localparam int NB = 23;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   data = 8'd0;
  logic         strobe = 1'b0;
  logic         sync = 1'b0;
  logic         clear_err = 1'b0;
  logic [0:183] whole184;
  logic         frame_valid;
  logic [7:0]   frame_count;
  logic         busy, terr, oerr, cerr;

  int           n_tests = 0;
  int           n_fail = 0;
  int           fv_cycles = 0;
  int           exp_count = 0;
  logic [0:183] exp_whole = '0;
  logic [7:0]   tx [0:23];

  rabbit_frame_receiver #(.TIMEOUT_CYCLES(T)) dut (
    .FITTYMEGA(clk), .RESET_N(rst_n), .RABBIT_DATA(data), .RABBIT_STROBE(strobe),
    .RABBIT_SYNC(sync), .whole184(whole184), .FRAME_VALID(frame_valid),
    .FRAME_COUNT(frame_count), .BUSY(busy), .TIMEOUT_ERR(terr), .OVERRUN_ERR(oerr),
    .CKSUM_ERR(cerr), .CLEAR_ERR(clear_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_cycles++;

  task automatic fill(input logic [7:0] base, input logic [7:0] step);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < 23; k++) begin
      tx[k] = 8'(base + 8'(k) * step);
      s = 8'(s + tx[k]);
    end
    tx[23] = s;
  endtask

  function automatic logic [0:183] tx_vec();
    logic [0:183] v;
    for (int k = 0; k < 23; k++) v[8*k +: 8] = tx[k];
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    data = b;
    repeat (3) @(negedge clk);
    strobe = 1'b1;
    repeat (3) @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    repeat (3) @(negedge clk);
    sync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_range(input int from, input int to);
    for (int k = from; k <= to; k++) send_byte(tx[k]);
  endtask

  task automatic send_frame();
    pulse_sync();
    send_range(0, NB - 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (whole184 !== '0 || frame_valid !== 1'b0 || frame_count !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: whole=%h fv=%b cnt=%0d busy=%b, required 0/0/0/0", whole184, frame_valid, frame_count, busy);
    end
    n_tests++;
    if (terr !== 1'b0 || oerr !== 1'b0 || cerr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: t=%b o=%b c=%b, required 000", terr, oerr, cerr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    fill(8'h00, 8'h01);
    fv_cycles = 0;
    send_frame();
    exp_count++;
    exp_whole = tx_vec();
    n_tests++;
    if (fv_cycles !== 1) begin
      n_fail++;
      $display("FAIL basic_fv_pulse: %0d cycles high, required 1", fv_cycles);
    end
    n_tests++;
    if (whole184[0:7] !== 8'h00 || whole184[176:183] !== 8'h16 || whole184 !== exp_whole) begin
      n_fail++;
      $display("FAIL basic_whole: got %h, required %h", whole184, exp_whole);
    end
    n_tests++;
    if (frame_count !== 8'd1 || terr !== 1'b0 || oerr !== 1'b0 || cerr !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: cnt=%0d t=%b o=%b c=%b busy=%b, required 1/0/0/0/0", frame_count, terr, oerr, cerr, busy);
    end
  endtask

  task automatic test_overrun();
    fill(8'hAA, 8'h00);
    send_frame();
    exp_count++;
    exp_whole = tx_vec();
    fill(8'h55, 8'h00);
    pulse_sync();
    send_range(0, 9);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_busy_partial: got %b, required 1", busy);
    end
    pulse_sync();
    n_tests++;
    if (oerr !== 1'b1 || whole184 !== exp_whole) begin
      n_fail++;
      $display("FAIL overrun_flag: oerr=%b whole=%h, required 1 and %h", oerr, whole184, exp_whole);
    end
    send_range(0, NB - 2);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_busy_restart: got %b, required 1", busy);
    end
    send_range(NB - 1, NB - 1);
    repeat (2) @(negedge clk);
    exp_count++;
    exp_whole = tx_vec();
    n_tests++;
    if (busy !== 1'b0 || whole184 !== exp_whole || frame_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL overrun_restart_frame: busy=%b cnt=%0d whole=%h, required 0/%0d/%h", busy, frame_count, whole184, exp_count, exp_whole);
    end
  endtask

  task automatic test_timeout();
    fill(8'h77, 8'h00);
    pulse_sync();
    send_range(0, 4);
    repeat (T - 1) @(negedge clk);
    n_tests++;
    if (terr !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: terr=%b busy=%b, required 0/1", terr, busy);
    end
    @(negedge clk);
    n_tests++;
    if (terr !== 1'b1 || busy !== 1'b0 || whole184 !== exp_whole) begin
      n_fail++;
      $display("FAIL timeout_at_count: terr=%b busy=%b whole=%h, required 1/0/%h", terr, busy, whole184, exp_whole);
    end
    send_byte(8'h11);
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_strobe: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_sync_with_strobe();
    fill(8'h3C, 8'h01);
    data = tx[0];
    repeat (3) @(negedge clk);
    sync = 1'b1;
    strobe = 1'b1;
    repeat (3) @(negedge clk);
    sync = 1'b0;
    strobe = 1'b0;
    send_range(1, NB - 1);
    repeat (2) @(negedge clk);
    exp_count++;
    exp_whole = tx_vec();
    n_tests++;
    if (whole184[0:7] !== 8'h3C || whole184 !== exp_whole || frame_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL sync_strobe_frame: whole=%h cnt=%0d, required %h/%0d", whole184, frame_count, exp_whole, exp_count);
    end
  endtask

`ifdef RABBIT_CHECKSUM_EN
  task automatic test_checksum();
    fill(8'h01, 8'h00);
    n_tests++;
    if (tx[23] !== 8'h17) begin
      n_fail++;
      $display("FAIL cksum_model: got %h, required 17", tx[23]);
    end
    send_frame();
    exp_count++;
    exp_whole = tx_vec();
    n_tests++;
    if (frame_count !== 8'(exp_count) || cerr !== 1'b0 || whole184 !== exp_whole) begin
      n_fail++;
      $display("FAIL cksum_good: cnt=%0d cerr=%b, required %0d/0", frame_count, cerr, exp_count);
    end
    tx[23] = 8'h18;
    tx[0] = 8'h01;
    fv_cycles = 0;
    send_frame();
    n_tests++;
    if (cerr !== 1'b1 || fv_cycles !== 0 || frame_count !== 8'(exp_count) || whole184 !== exp_whole) begin
      n_fail++;
      $display("FAIL cksum_bad: cerr=%b fv=%0d cnt=%0d, required 1/0/%0d", cerr, fv_cycles, frame_count, exp_count);
    end
  endtask
`endif

  task automatic test_wrap_and_clear();
    fill(8'h20, 8'h03);
    while (exp_count < 256) begin
      send_frame();
      exp_count++;
    end
    exp_whole = tx_vec();
    n_tests++;
    if (frame_count !== 8'd0 || whole184 !== exp_whole) begin
      n_fail++;
      $display("FAIL count_wrap: cnt=%0d, required 0", frame_count);
    end
    pulse_sync();
    send_range(0, 1);
    repeat (T - 1) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
    n_tests++;
    if (terr !== 1'b0 || oerr !== 1'b0 || cerr !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_vs_timeout: t=%b o=%b c=%b busy=%b, required 0000", terr, oerr, cerr, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    fill(8'h90, 8'h01);
    pulse_sync();
    send_range(0, 3);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || whole184 !== '0 || frame_count !== 8'd0 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: busy=%b cnt=%0d fv=%b, required 0/0/0", busy, frame_count, frame_valid);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame();
    exp_whole = tx_vec();
    n_tests++;
    if (frame_count !== 8'd1 || whole184 !== exp_whole) begin
      n_fail++;
      $display("FAIL after_reset_frame: cnt=%0d whole=%h, required 1/%h", frame_count, whole184, exp_whole);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overrun();
    test_timeout();
    test_sync_with_strobe();
`ifdef RABBIT_CHECKSUM_EN
    test_checksum();
`endif
    test_wrap_and_clear();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
